// File: rtl/execute_stage_if.sv
// Decode->execute->mem boundary bundle for the EX stage.
// slave  : execute_stage side (consumes de_*, drives exe_*)
// master : upstream/downstream side (drives de_*, observes exe_*)
interface execute_stage_if;
    logic [3:0]  de_aluop;
    logic [31:0] de_alusrc1;
    logic [31:0] de_alusrc2;
    logic [32:0] de_extend_rs;
    logic [32:0] de_extend_rt;
    logic        de_mem_en;
    logic [3:0]  de_mem_wen;
    logic [31:0] de_mem_wdata;
    logic        de_reg_en;
    logic        de_mem_read;
    logic [5:0]  de_reg_waddr;
    logic        de_double_en;
    logic        de_mul;
    logic        de_div;

    logic [31:0] exe_result;
    logic [31:0] exe_hi;
    logic        exe_reg_en;
    logic [5:0]  exe_reg_waddr;
    logic        exe_mem_read;
    logic        exe_mem_en;
    logic [3:0]  exe_mem_wen;
    logic [31:0] exe_mem_wdata;
    logic        exe_double_en;
    logic        exe_stall;

    modport slave (
        input  de_aluop, de_alusrc1, de_alusrc2, de_extend_rs, de_extend_rt,
               de_mem_en, de_mem_wen, de_mem_wdata, de_reg_en, de_mem_read,
               de_reg_waddr, de_double_en, de_mul, de_div,
        output exe_result, exe_hi, exe_reg_en, exe_reg_waddr, exe_mem_read,
               exe_mem_en, exe_mem_wen, exe_mem_wdata, exe_double_en, exe_stall
    );

    modport master (
        output de_aluop, de_alusrc1, de_alusrc2, de_extend_rs, de_extend_rt,
               de_mem_en, de_mem_wen, de_mem_wdata, de_reg_en, de_mem_read,
               de_reg_waddr, de_double_en, de_mul, de_div,
        input  exe_result, exe_hi, exe_reg_en, exe_reg_waddr, exe_mem_read,
               exe_mem_en, exe_mem_wen, exe_mem_wdata, exe_double_en, exe_stall
    );
endinterface

// File: rtl/execute_stage.sv
// MIPS EX stage: single-cycle ALU plus multicycle MULT/MULTU/DIV/DIVU
// producing HI/LO.
// Ports:
//   clk    : pipeline clock
//   resetn : async active-low reset
//   ex     : execute_stage_if.slave -- de_* decode inputs, exe_* registered
//            mem-stage inputs, exe_stall (combinational hold request)
module execute_stage #(
    parameter int DIV_BITS = 33
) (
    input  logic          clk,
    input  logic          resetn,
    execute_stage_if.slave ex
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    localparam int CW = $clog2(DIV_BITS);
    localparam logic [CW-1:0] LAST = CW'(DIV_BITS - 1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_stall;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                if (ex.de_mul) begin
                    w_state_nxt = MUL;
                    w_stall     = 1'b1;
                end else if (ex.de_div) begin
                    w_state_nxt = DIV;
                    w_cnt_nxt   = '0;
                    w_stall     = 1'b1;
                end
            end
            MUL: w_state_nxt = IDLE;
            DIV: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_stall   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign ex.exe_stall = w_stall;

    // ---------------- mul/div datapath ----------------
    logic [32:0] r_a, r_b;        // captured signed operands
    logic [32:0] r_dq;            // dividend bits shift out, quotient bits shift in
    logic [32:0] r_rem, r_dvs;    // partial remainder, divisor magnitude
    logic [32:0] w_mag_a, w_mag_b;
    logic [33:0] w_shift, w_diff;
    logic        w_ge;
    logic [32:0] w_rem_nxt, w_q_nxt;
    logic [63:0] w_prod;
    logic [31:0] w_div_lo, w_div_hi;

    assign w_mag_a = ex.de_extend_rs[32] ? -ex.de_extend_rs : ex.de_extend_rs;
    assign w_mag_b = ex.de_extend_rt[32] ? -ex.de_extend_rt : ex.de_extend_rt;

    // One restoring step; the final step's result is used directly at the
    // last DIV edge, so DIV_BITS cycles yield DIV_BITS quotient bits.
    assign w_shift   = {r_rem, r_dq[32]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_ge      = ~w_diff[33];
    assign w_rem_nxt = w_ge ? w_diff[32:0] : w_shift[32:0];
    assign w_q_nxt   = {r_dq[31:0], w_ge};

    // Sign-extending to 64 bits makes the low 64 product bits exact for
    // both signed and zero-extended (unsigned) operands.
    assign w_prod = {{31{r_a[32]}}, r_a} * {{31{r_b[32]}}, r_b};

    always_comb begin
        w_div_lo = (r_a[32] ^ r_b[32]) ? -w_q_nxt[31:0] : w_q_nxt[31:0];
        w_div_hi = r_a[32] ? -w_rem_nxt[31:0] : w_rem_nxt[31:0];
        if (r_dvs == '0) begin
            w_div_lo = 32'hFFFF_FFFF;
            w_div_hi = r_a[31:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a   <= '0;
            r_b   <= '0;
            r_dq  <= '0;
            r_rem <= '0;
            r_dvs <= '0;
        end else if (r_state == IDLE && (ex.de_mul || ex.de_div)) begin
            r_a   <= ex.de_extend_rs;
            r_b   <= ex.de_extend_rt;
            r_dq  <= w_mag_a;
            r_rem <= '0;
            r_dvs <= w_mag_b;
        end else if (r_state == DIV) begin
            r_dq  <= w_q_nxt;
            r_rem <= w_rem_nxt;
        end
    end

    // ---------------- ALU ----------------
    logic [31:0] w_alu;
    logic [4:0]  w_sa;
    assign w_sa = ex.de_alusrc1[4:0];

    always_comb begin
        w_alu = '0;
        case (ex.de_aluop)
            4'd0:  w_alu = ex.de_alusrc1 & ex.de_alusrc2;
            4'd1:  w_alu = ex.de_alusrc1 | ex.de_alusrc2;
            4'd2:  w_alu = ex.de_alusrc1 + ex.de_alusrc2;
            4'd3:  w_alu = ex.de_alusrc1 - ex.de_alusrc2;
            4'd4:  w_alu = {31'b0, $signed(ex.de_alusrc1) < $signed(ex.de_alusrc2)};
            4'd5:  w_alu = {31'b0, ex.de_alusrc1 < ex.de_alusrc2};
            4'd6:  w_alu = ex.de_alusrc2 << w_sa;
            4'd7:  w_alu = ex.de_alusrc2 >> w_sa;
            4'd9:  w_alu = $unsigned($signed(ex.de_alusrc2) >>> w_sa);
            4'd10: w_alu = {ex.de_alusrc2[15:0], 16'h0};
            4'd11: w_alu = ex.de_alusrc1 ^ ex.de_alusrc2;
            4'd12: w_alu = ~(ex.de_alusrc1 | ex.de_alusrc2);
            default: w_alu = '0;
        endcase
    end

    // ---------------- EX/MEM registers ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn || w_stall) begin
            // reset, or bubble while a multicycle op is still running
            ex.exe_result    <= '0;
            ex.exe_hi        <= '0;
            ex.exe_reg_en    <= 1'b0;
            ex.exe_reg_waddr <= '0;
            ex.exe_mem_read  <= 1'b0;
            ex.exe_mem_en    <= 1'b0;
            ex.exe_mem_wen   <= '0;
            ex.exe_mem_wdata <= '0;
            ex.exe_double_en <= 1'b0;
        end else if (r_state == MUL || r_state == DIV) begin
            ex.exe_result    <= (r_state == MUL) ? w_prod[31:0]  : w_div_lo;
            ex.exe_hi        <= (r_state == MUL) ? w_prod[63:32] : w_div_hi;
            ex.exe_reg_en    <= 1'b0;
            ex.exe_reg_waddr <= '0;
            ex.exe_mem_read  <= 1'b0;
            ex.exe_mem_en    <= 1'b0;
            ex.exe_mem_wen   <= '0;
            ex.exe_mem_wdata <= '0;
            ex.exe_double_en <= 1'b1;
        end else begin
            ex.exe_result    <= w_alu;
            ex.exe_hi        <= '0;
            ex.exe_reg_en    <= ex.de_reg_en;
            ex.exe_reg_waddr <= ex.de_reg_waddr;
            ex.exe_mem_read  <= ex.de_mem_read;
            ex.exe_mem_en    <= ex.de_mem_en;
            ex.exe_mem_wen   <= ex.de_mem_wen;
            ex.exe_mem_wdata <= ex.de_mem_wdata;
            ex.exe_double_en <= ex.de_double_en;
        end
    end
endmodule
